// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter fed by a small word FIFO. Frame format (data
//            bits, parity, stop bits) is fixed at elaboration. Frames are sent
//            back to back with no idle gap while the FIFO holds data.
// Ports    : clk       - system clock, rising edge
//            rst_n     - asynchronous reset, active low
//            tx_start  - push strobe; pushes tx_data when tx_full is low
//            tx_data   - DATA_BITS-wide word to send
//            tx        - registered serial line, idles high
//            tx_busy   - high while a frame is in progress or FIFO non-empty
//            tx_full   - registered FIFO-full flag
//            tx_drop   - one-cycle pulse when a push hit a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_full,
    output logic                 tx_drop
);

    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    // Odd parity is the inverted XOR of the data bits.
    localparam logic              PAR_INV   = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic [DATA_BITS-1:0] head;

    // ------------------------------------------------------------------
    // Transmit FSM state
    // ------------------------------------------------------------------
    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic push;
    logic pop;
    logic empty;
    logic baud_last;
    logic stop_end;
    logic idle_next;

    // A push is refused whenever the registered full flag is set, even if a
    // pop in the same cycle would have made room.
    assign push      = tx_start && !tx_full;
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign stop_end  = (state == STOP) && baud_last && (bit_cnt == STOP_LAST);
    // The FSM takes a word either from IDLE or at the very last stop cycle,
    // the latter giving gap-free back-to-back frames.
    assign pop       = !empty && ((state == IDLE) || stop_end);
    assign idle_next = ((state == IDLE) || stop_end) && !pop;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Storage carries no reset; only the pointers and count are flushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx_full <= 1'b0;
            tx_drop <= 1'b0;
            tx_busy <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            tx_full <= (count_next == DEPTH_C);
            tx_drop <= tx_start && tx_full;
            tx_busy <= !idle_next || (count_next != '0);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM with registered line output. The baud counter restarts
    // on every state entry so each bit lasts exactly DIV cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= (^head) ^ PAR_INV;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                        shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                PAR: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shreg   <= head;
                                par_bit <= (^head) ^ PAR_INV;
                                tx      <= 1'b0;
                                state   <= START;
                            end else begin
                                tx    <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
